// File: rtl/clk_tick_gen.sv
// Lock-qualified 1 us / 1 ms / 1 s clock-enable strobe generator with a
// 0..59 seconds counter and minute strobe, for the PLL output clock domain.
module clk_tick_gen #(
    parameter int US_DIV        = 48,
    parameter int MS_DIV        = 1000,
    parameter int S_DIV         = 1000,
    parameter int SETTLE_CYCLES = 1024
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pll_lock,
    input  logic       run,
    output logic       ready,
    output logic       tick_us,
    output logic       tick_ms,
    output logic       tick_sec,
    output logic [5:0] sec_count,
    output logic       tick_min
);
    localparam int UW = $clog2(US_DIV);
    localparam int MW = $clog2(MS_DIV);
    localparam int SW = $clog2(S_DIV);
    localparam int CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

    localparam logic [UW-1:0] US_LAST = UW'(US_DIV - 1);
    localparam logic [MW-1:0] MS_LAST = MW'(MS_DIV - 1);
    localparam logic [SW-1:0] S_LAST  = SW'(S_DIV - 1);
    // RUN is entered on the edge where the counter steps onto SETTLE_CYCLES-1.
    localparam logic [CW-1:0] SETTLE_PRE = CW'((SETTLE_CYCLES > 1) ? SETTLE_CYCLES - 2 : 0);

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        SETTLE    = 2'd1,
        RUN       = 2'd2
    } state_t;

    state_t        state;
    logic          lock_m, lock_s;
    logic [CW-1:0] settle_cnt;
    logic [UW-1:0] us_cnt;
    logic [MW-1:0] ms_cnt;
    logic [SW-1:0] s_cnt;

    logic live, us_wrap, ms_wrap, s_wrap, m_wrap;

    always_ff @(posedge clk) begin
        if (rst) begin
            lock_m <= 1'b0;
            lock_s <= 1'b0;
        end else begin
            lock_m <= pll_lock;
            lock_s <= lock_m;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= WAIT_LOCK;
            settle_cnt <= '0;
            ready      <= 1'b0;
        end else begin
            case (state)
                WAIT_LOCK: begin
                    settle_cnt <= '0;
                    if (lock_s) begin
                        if (SETTLE_CYCLES == 1) begin
                            state <= RUN;
                            ready <= 1'b1;
                        end else begin
                            state <= SETTLE;
                        end
                    end
                end
                SETTLE: begin
                    if (!lock_s) begin
                        state      <= WAIT_LOCK;
                        settle_cnt <= '0;
                    end else begin
                        settle_cnt <= settle_cnt + CW'(1);
                        if (settle_cnt == SETTLE_PRE) begin
                            state <= RUN;
                            ready <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (!lock_s) begin
                        state      <= WAIT_LOCK;
                        settle_cnt <= '0;
                        ready      <= 1'b0;
                    end
                end
                default: begin
                    state      <= WAIT_LOCK;
                    settle_cnt <= '0;
                    ready      <= 1'b0;
                end
            endcase
        end
    end

    // Lock loss is folded into live so a tick due on that edge is dropped.
    assign live    = (state == RUN) && lock_s;
    assign us_wrap = (us_cnt == US_LAST);
    assign ms_wrap = us_wrap && (ms_cnt == MS_LAST);
    assign s_wrap  = ms_wrap && (s_cnt == S_LAST);
    assign m_wrap  = s_wrap && (sec_count == 6'd59);

    always_ff @(posedge clk) begin
        if (rst || !live) begin
            us_cnt    <= '0;
            ms_cnt    <= '0;
            s_cnt     <= '0;
            sec_count <= '0;
            tick_us   <= 1'b0;
            tick_ms   <= 1'b0;
            tick_sec  <= 1'b0;
            tick_min  <= 1'b0;
        end else if (!run) begin
            tick_us  <= 1'b0;
            tick_ms  <= 1'b0;
            tick_sec <= 1'b0;
            tick_min <= 1'b0;
        end else begin
            us_cnt <= us_wrap ? '0 : us_cnt + UW'(1);
            if (us_wrap)
                ms_cnt <= (ms_cnt == MS_LAST) ? '0 : ms_cnt + MW'(1);
            if (ms_wrap)
                s_cnt <= (s_cnt == S_LAST) ? '0 : s_cnt + SW'(1);
            if (s_wrap)
                sec_count <= m_wrap ? 6'd0 : sec_count + 6'd1;
            tick_us  <= us_wrap;
            tick_ms  <= ms_wrap;
            tick_sec <= s_wrap;
            tick_min <= m_wrap;
        end
    end
endmodule
